misao_mem_responder: RTL and testbench
======================================

# misao_mem_responder

Memory-side responder for the MISA-O nibble bus: owns a nibble-wide program/data RAM, answers core fetch/load requests with a programmable number of wait states, and accepts single-cycle core stores. Also provides a host preload port that stalls the core while the RAM is written or read back. It sits between the `misao` core and the top level, driving the core's `mem_enable_read`, `mem_enable_write` and `mem_data_in`.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 nibbles; upper address bits ignored (aliasing).
- `WAIT_STATES`, default 1: cycles inserted before each read completes; legal range 0–15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_addr` in 16: address from core.
- `mem_rw` in 1: 1 = read, 0 = write request from core.
- `mem_data_out` in 4: store data from core, valid only while `mem_enable_write`=1.
- `mem_enable_read` out 1: one-cycle read-complete strobe; the core advances on it.
- `mem_enable_write` out 1: write grant; the core drives `mem_data_out` while this is high and `mem_enable_read` is low.
- `mem_data_in` out 4: read data to core, registered.
- `host_hold` in 1: stalls the core and enables the host port.
- `host_we` in 1: host write strobe, honoured only in HOLD.
- `host_addr` in DEPTH_LOG2: host RAM address.
- `host_wdata` in 4: host write data.
- `host_rdata` out 4: registered RAM[host_addr], one cycle after the address.
- `busy` out 1: high in WAIT and READ_VALID.

## Operation
- States: HOLD, IDLE, WAIT, READ_VALID.
- Reset values: state = IDLE; all outputs 0; wait counter 0. RAM contents are not reset.
- HOLD:
  - Entered from any state at the first edge with `host_hold`=1, including mid-read. A pending read is discarded with no strobe.
  - `mem_enable_read`=`mem_enable_write`=0.
  - `host_we`=1 writes `host_wdata` to RAM[`host_addr`] at the edge.
  - `host_hold`=0 → IDLE.
- IDLE, `mem_rw`=1:
  - Latch `mem_addr[DEPTH_LOG2-1:0]`.
  - Next state WAIT with counter = WAIT_STATES-1, or READ_VALID if WAIT_STATES=0.
- IDLE, `mem_rw`=0 (store):
  - `mem_enable_write` is combinational: (state==IDLE && !mem_rw && !host_hold).
  - RAM[`mem_addr`] ← `mem_data_out` at that same edge.
  - Remain in IDLE. The core holds `mem_rw`=0 for exactly one cycle.
- WAIT: decrement the counter; at 0 → READ_VALID.
- READ_VALID:
  - `mem_enable_read`=1 for exactly one cycle; `mem_data_in` = RAM[latched addr], registered on entry.
  - `mem_data_in` holds its value until the next READ_VALID.
  - Next state IDLE.
- `mem_enable_read` and `mem_enable_write` are never high together.
- Host port writes are ignored outside HOLD. Core requests are ignored in HOLD.

## Timing
- Read latency from IDLE sampling `mem_rw`=1 to the `mem_enable_read` cycle: WAIT_STATES+1 cycles.
- Sustained fetch period: WAIT_STATES+2 cycles per nibble.
- A store completes in 0 extra cycles (same cycle as the request).
- A new core write and an old read-complete cannot coincide, because writes are accepted only in IDLE.
- `rst` asserted mid-read: outputs drop to 0 asynchronously; no strobe is emitted.
- `host_rdata` latency is 1 cycle in every state; it is a read-only side port.
- Address aliasing: `mem_addr` 0x0400 with DEPTH_LOG2=10 maps to RAM[0].

## Structure
- Package `misao_mem_pkg` holds:
  - state enum `mem_state_t` {HOLD, IDLE, WAIT, READ_VALID};
  - `MISAO_ADDR_W`=16 and `MISAO_NIBBLE_W`=4;
  - the opcode constants, shared with the core.
- Sub-module `misao_nibble_ram`:
  - two ports, one synchronous write, two registered reads;
  - the write port is muxed between core and host by state.
- The responder itself is the FSM, the wait counter and the address latch.

## Test plan
- Host preload: hold=1, write 0x3@0, 0xC@1, 0x5@2. Readback gives `host_rdata` 3, C, 5, each one cycle after its address.
- Fetch with WAIT_STATES=1: release hold, request addr 0. `mem_enable_read` pulses on cycle 3 after IDLE sampling with `mem_data_in`=0x3. Next fetch strobes 3 cycles later with 0xC.
- WAIT_STATES=0: back-to-back fetches strobe every 2 cycles, with data matching the preload.
- Store: `mem_rw`=0, addr 0x0010, `mem_data_out`=0xA. `mem_enable_write`=1 that cycle with `mem_enable_read`=0. A later fetch of 0x10 returns 0xA. Address 0x0410 aliases to the same location.
- Hold mid-read: raise `host_hold` during WAIT. No `mem_enable_read` strobe occurs and state = HOLD; after release, the next request completes normally.
- Async reset during READ_VALID: all outputs are 0 immediately, state = IDLE, and RAM contents are preserved.

Source files
------------

// File: rtl/misao_mem_pkg.sv
// Shared types and constants for the MISA-O nibble memory bus.
// Imported by the core-side responder and its RAM.
package misao_mem_pkg;

    localparam int MISAO_ADDR_W   = 16;
    localparam int MISAO_NIBBLE_W = 4;

    // Bus request encoding on mem_rw, shared with the core
    localparam logic MEM_OP_READ  = 1'b1;
    localparam logic MEM_OP_WRITE = 1'b0;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        IDLE       = 2'd1,
        WAIT       = 2'd2,
        READ_VALID = 2'd3
    } mem_state_t;

endpackage

// File: rtl/misao_nibble_ram.sv
// Nibble-wide RAM: one synchronous write port, a core read port with read
// enable (data holds between reads) and an always-on registered host read port.
module misao_nibble_ram
    import misao_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [DEPTH_LOG2-1:0]     waddr,
    input  logic [MISAO_NIBBLE_W-1:0] wdata,
    input  logic                      core_re,
    input  logic [DEPTH_LOG2-1:0]     core_raddr,
    output logic [MISAO_NIBBLE_W-1:0] core_rdata,
    input  logic [DEPTH_LOG2-1:0]     host_raddr,
    output logic [MISAO_NIBBLE_W-1:0] host_rdata
);

    logic [MISAO_NIBBLE_W-1:0] mem_r [0:(2**DEPTH_LOG2)-1];

    // Storage array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Core read register: loads only on a read strobe so data holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rdata <= 4'h0;
        end else if (core_re) begin
            core_rdata <= mem_r[core_raddr];
        end
    end

    // Host read register: follows host_raddr every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rdata <= 4'h0;
        end else begin
            host_rdata <= mem_r[host_raddr];
        end
    end

endmodule

// File: rtl/misao_mem_responder.sv
// MISA-O memory responder: read FSM with programmable wait states, single-cycle
// core stores, and a host preload port that holds the core off the bus.
module misao_mem_responder
    import misao_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MISAO_ADDR_W-1:0]   mem_addr,
    input  logic                      mem_rw,
    input  logic [MISAO_NIBBLE_W-1:0] mem_data_out,
    output logic                      mem_enable_read,
    output logic                      mem_enable_write,
    output logic [MISAO_NIBBLE_W-1:0] mem_data_in,
    input  logic                      host_hold,
    input  logic                      host_we,
    input  logic [DEPTH_LOG2-1:0]     host_addr,
    input  logic [MISAO_NIBBLE_W-1:0] host_wdata,
    output logic [MISAO_NIBBLE_W-1:0] host_rdata,
    output logic                      busy
);

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    mem_state_t                state_r, state_s;
    logic [3:0]                wait_cnt_r, wait_cnt_s;
    logic [DEPTH_LOG2-1:0]     addr_r, addr_s;
    logic                      rd_strobe_r;
    logic                      busy_r;
    logic                      ram_we_s;
    logic [DEPTH_LOG2-1:0]     ram_waddr_s;
    logic [MISAO_NIBBLE_W-1:0] ram_wdata_s;
    logic                      core_re_s;
    logic                      unused_addr_s;

    // Upper core address bits alias onto the RAM
    assign unused_addr_s = ^mem_addr[MISAO_ADDR_W-1:DEPTH_LOG2];

    // Next-state, wait counter and read address latch
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        addr_s     = addr_r;
        if (host_hold) begin
            state_s = HOLD;
        end else begin
            case (state_r)
                HOLD: state_s = IDLE;
                IDLE: begin
                    if (mem_rw == MEM_OP_READ) begin
                        addr_s = mem_addr[DEPTH_LOG2-1:0];
                        if (WAIT_STATES == 0) begin
                            state_s = READ_VALID;
                        end else begin
                            state_s    = WAIT;
                            wait_cnt_s = WAIT_INIT;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_s = READ_VALID;
                    end else begin
                        wait_cnt_s = wait_cnt_r - 4'd1;
                    end
                end
                READ_VALID: state_s = IDLE;
                default:    state_s = IDLE;
            endcase
        end
    end

    // Store grant is combinational so the core's store completes in its own cycle
    assign mem_enable_write = (state_r == IDLE) && (mem_rw == MEM_OP_WRITE) && !host_hold;

    // RAM write port belongs to the host in HOLD and to the core otherwise
    always_comb begin
        if (state_r == HOLD) begin
            ram_we_s    = host_we;
            ram_waddr_s = host_addr;
            ram_wdata_s = host_wdata;
        end else begin
            ram_we_s    = mem_enable_write;
            ram_waddr_s = mem_addr[DEPTH_LOG2-1:0];
            ram_wdata_s = mem_data_out;
        end
    end

    // Read data is captured on the edge that enters READ_VALID
    assign core_re_s = (state_s == READ_VALID);

    // FSM state, counter, latch and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            addr_r      <= '0;
            rd_strobe_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            addr_r      <= addr_s;
            rd_strobe_r <= (state_s == READ_VALID);
            busy_r      <= (state_s == WAIT) || (state_s == READ_VALID);
        end
    end

    assign mem_enable_read = rd_strobe_r;
    assign busy            = busy_r;

    misao_nibble_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we        (ram_we_s),
        .waddr     (ram_waddr_s),
        .wdata     (ram_wdata_s),
        .core_re   (core_re_s),
        .core_raddr(addr_s),
        .core_rdata(mem_data_in),
        .host_raddr(host_addr),
        .host_rdata(host_rdata)
    );

endmodule

// File: tb/tb_misao_mem_responder.sv
// Directed bench: one responder with WAIT_STATES=1 and one with WAIT_STATES=0,
// sharing clock, reset and host port, each with its own core-side inputs.
module tb_misao_mem_responder;
    import misao_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_hold, host_we;
    logic [9:0]  host_addr;
    logic [3:0]  host_wdata;

    logic        rw1, rd1, wr1, busy1;
    logic [15:0] addr1;
    logic [3:0]  dout1, din1, hrd1;
    logic        rw0, rd0, wr0, busy0;
    logic [15:0] addr0;
    logic [3:0]  dout0, din0, hrd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    misao_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_addr(addr1), .mem_rw(rw1), .mem_data_out(dout1),
        .mem_enable_read(rd1), .mem_enable_write(wr1), .mem_data_in(din1),
        .host_hold(host_hold), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(hrd1), .busy(busy1)
    );

    misao_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_addr(addr0), .mem_rw(rw0), .mem_data_out(dout0),
        .mem_enable_read(rd0), .mem_enable_write(wr0), .mem_data_in(din0),
        .host_hold(host_hold), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(hrd0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_step(input int k, input logic [15:0] a1, input logic [15:0] a0,
                              input logic e_rd1, input logic [3:0] e_d1,
                              input logic e_rd0, input logic [3:0] e_d0);
        addr1 = a1;
        addr0 = a0;
        step();
        chk($sformatf("fetch%0d rd_ws1", k), 16'(rd1), 16'(e_rd1));
        chk($sformatf("fetch%0d data_ws1", k), 16'(din1), 16'(e_d1));
        chk($sformatf("fetch%0d rd_ws0", k), 16'(rd0), 16'(e_rd0));
        chk($sformatf("fetch%0d data_ws0", k), 16'(din0), 16'(e_d0));
        chk($sformatf("fetch%0d no_write", k), 16'(wr1 | wr0), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        host_hold = 1'b0; host_we = 1'b0; host_addr = 10'd0; host_wdata = 4'h0;
        rw1 = 1'b1; addr1 = 16'h0000; dout1 = 4'h0;
        rw0 = 1'b1; addr0 = 16'h0000; dout0 = 4'h0;

        #12;
        chk("reset rd", 16'(rd1), 16'd0);
        chk("reset wr", 16'(wr1), 16'd0);
        chk("reset data", 16'(din1), 16'd0);
        chk("reset busy", 16'(busy1), 16'd0);
        chk("reset host_rdata", 16'(hrd1), 16'd0);
        chk("reset state", 16'(u_dut1.state_r), 16'(IDLE));

        // Host preload
        @(posedge clk); #1;
        rst = 1'b0;
        host_hold = 1'b1;
        step();
        chk("hold entry state", 16'(u_dut1.state_r), 16'(HOLD));
        host_we = 1'b1;
        host_addr = 10'd0; host_wdata = 4'h3; step();
        host_addr = 10'd1; host_wdata = 4'hC; step();
        host_addr = 10'd2; host_wdata = 4'h5; step();
        host_we = 1'b0;
        host_addr = 10'd0; step();
        chk("preload rd @0", 16'(hrd1), 16'h3);
        host_addr = 10'd1;
        #1;
        chk("host_rdata latency", 16'(hrd1), 16'h3);
        step();
        chk("preload rd @1", 16'(hrd1), 16'hC);
        host_addr = 10'd2; step();
        chk("preload rd @2", 16'(hrd1), 16'h5);
        chk("preload ws0 @2", 16'(hrd0), 16'h5);

        // Release hold; both responders fetch
        host_hold = 1'b0;
        step();
        chk("release state", 16'(u_dut1.state_r), 16'(IDLE));
        fetch_step(1, 16'h0000, 16'h0000, 1'b0, 4'h0, 1'b1, 4'h3);
        chk("ws1 busy in WAIT", 16'(busy1), 16'd1);
        fetch_step(2, 16'h0001, 16'h0001, 1'b1, 4'h3, 1'b0, 4'h3);
        fetch_step(3, 16'h0001, 16'h0001, 1'b0, 4'h3, 1'b1, 4'hC);
        fetch_step(4, 16'h0001, 16'h0002, 1'b0, 4'h3, 1'b0, 4'hC);
        fetch_step(5, 16'h0001, 16'h0002, 1'b1, 4'hC, 1'b1, 4'h5);
        fetch_step(6, 16'h0001, 16'h0002, 1'b0, 4'hC, 1'b0, 4'h5);

        // Stores: 0x0010 on ws1, aliased 0x0410 on ws0
        rw1 = 1'b0; addr1 = 16'h0010; dout1 = 4'hA;
        rw0 = 1'b0; addr0 = 16'h0410; dout0 = 4'hB;
        #1;
        chk("store wr_ws1", 16'(wr1), 16'd1);
        chk("store rd_ws1", 16'(rd1), 16'd0);
        chk("store wr_ws0", 16'(wr0), 16'd1);
        step();
        rw1 = 1'b1; addr1 = 16'h0410;
        rw0 = 1'b1; addr0 = 16'h0010;
        #1;
        chk("write drops", 16'(wr1), 16'd0);
        step();
        chk("alias fetch rd_ws0", 16'(rd0), 16'd1);
        chk("alias fetch data_ws0", 16'(din0), 16'hB);
        step();
        chk("alias fetch rd_ws1", 16'(rd1), 16'd1);
        chk("alias fetch data_ws1", 16'(din1), 16'hA);
        step();

        // Hold mid-read; host write outside HOLD must be ignored
        host_we = 1'b1; host_addr = 10'd0; host_wdata = 4'hF;
        step();
        chk("mid-read busy", 16'(busy1), 16'd1);
        host_we = 1'b0;
        host_hold = 1'b1;
        step();
        chk("hold mid-read state", 16'(u_dut1.state_r), 16'(HOLD));
        chk("hold mid-read rd", 16'(rd1), 16'd0);
        chk("hold busy", 16'(busy1), 16'd0);
        step();
        chk("hold rd 2", 16'(rd1), 16'd0);
        chk("ignored host write", 16'(hrd1), 16'h3);
        host_hold = 1'b0; addr1 = 16'h0002;
        step();
        chk("post-hold rd a", 16'(rd1), 16'd0);
        step();
        chk("post-hold rd b", 16'(rd1), 16'd0);
        step();
        chk("post-hold fetch rd", 16'(rd1), 16'd1);
        chk("post-hold fetch data", 16'(din1), 16'h5);

        // Async reset during READ_VALID
        #2;
        rst = 1'b1;
        #1;
        chk("async rst rd", 16'(rd1), 16'd0);
        chk("async rst data", 16'(din1), 16'd0);
        chk("async rst busy", 16'(busy1), 16'd0);
        chk("async rst wr", 16'(wr1), 16'd0);
        chk("async rst state", 16'(u_dut1.state_r), 16'(IDLE));
        #1;
        rst = 1'b0;
        host_hold = 1'b1; host_addr = 10'd2;
        step();
        chk("ram kept @2", 16'(hrd1), 16'h5);
        host_addr = 10'h010;
        step();
        chk("ram kept @10 ws1", 16'(hrd1), 16'hA);
        chk("ram kept @10 ws0", 16'(hrd0), 16'hB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
